// File: rtl/fnd_pkg.sv
// Shared types, constants and the hex segment font for the FND scan controller.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CONV_BITS  = 12;
    localparam logic [7:0]  FONT_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off
    function automatic logic [7:0] hex_font(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'b0000_0011;
            4'h1: s = 8'b1001_1111;
            4'h2: s = 8'b0010_0101;
            4'h3: s = 8'b0000_1101;
            4'h4: s = 8'b1001_1001;
            4'h5: s = 8'b0100_1001;
            4'h6: s = 8'b0100_0001;
            4'h7: s = 8'b0001_1111;
            4'h8: s = 8'b0000_0001;
            4'h9: s = 8'b0000_1001;
            4'hA: s = 8'b0001_0001;
            4'hB: s = 8'b1100_0001;
            4'hC: s = 8'b0110_0011;
            4'hD: s = 8'b1000_0101;
            4'hE: s = 8'b0110_0001;
            default: s = 8'b0111_0001;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Value-load handshake between a requester and the FND scan controller.
interface fnd_scan_controller_if;
    import fnd_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DISP_W-1:0] in_value;
    logic              in_dec;
    logic              in_blank_lz;

    modport master (output in_valid, in_value, in_dec, in_blank_lz, input in_ready);
    modport slave  (input in_valid, in_value, in_dec, in_blank_lz, output in_ready);
endinterface

// File: rtl/fnd_bcd_seq.sv
// Sequential double-dabble: one binary bit per cycle, CONV_BITS cycles after i_start.
module fnd_bcd_seq
    import fnd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic [CONV_BITS-1:0] i_bin,
    output logic                 o_done_c,
    output logic [DISP_W-1:0]    o_bcd
);
    localparam int unsigned ITER_W = $clog2(CONV_BITS);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(CONV_BITS - 1);

    logic [CONV_BITS-1:0] r_bin;
    logic [DISP_W-1:0]    r_bcd;
    logic [ITER_W-1:0]    r_iter;
    logic                 r_active;
    logic [DISP_W-1:0]    w_adj;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[DIGIT_W*k +: DIGIT_W] >= 4'd5)
                w_adj[DIGIT_W*k +: DIGIT_W] = r_bcd[DIGIT_W*k +: DIGIT_W] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_iter   <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_bin    <= i_bin;
            r_bcd    <= '0;
            r_iter   <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd <= DISP_W'({w_adj, r_bin[CONV_BITS-1]});
            r_bin <= {r_bin[CONV_BITS-2:0], 1'b0};
            if (r_iter == ITER_LAST) begin
                r_iter   <= '0;
                r_active <= 1'b0;
            end else begin
                r_iter <= r_iter + ITER_W'(1);
            end
        end
    end

    assign o_done_c = r_active && (r_iter == ITER_LAST);
    assign o_bcd    = r_bcd;

endmodule

// File: rtl/fnd_scan_controller.sv
// Loads a hex/decimal value, commits it atomically and time-multiplexes the 4-digit FND.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 125000,
    parameter bit          COM_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fnd_scan_controller_if.slave  in_bus,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] com,
    output logic [7:0]            seg_7
);
    localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] COM_XOR = {NUM_DIGITS{COM_ACTIVE_LOW}};

    state_t              r_state, w_state_next;
    logic                w_accept, w_start, w_commit;
    logic                r_ready, r_busy;
    logic [DISP_W-1:0]   r_value;
    logic                r_dec, r_blank_lz;
    logic [DISP_W-1:0]   r_disp_digits;
    logic                r_disp_blank;
    logic                w_bcd_done;
    logic [DISP_W-1:0]   w_bcd;

    logic [PRE_W-1:0]      r_pre;
    logic [1:0]            r_idx, w_idx_next;
    logic [NUM_DIGITS-1:0] r_com, w_com;
    logic [7:0]            r_seg, w_seg;
    logic [NUM_DIGITS-1:0] w_zero, w_lead;
    logic                  w_pre_tc;

    fnd_bcd_seq u_bcd (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_start),
        .i_bin    (in_bus.in_value[CONV_BITS-1:0]),
        .o_done_c (w_bcd_done),
        .o_bcd    (w_bcd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = in_bus.in_valid && r_ready;
                if (w_accept) begin
                    w_start      = in_bus.in_dec;
                    w_state_next = in_bus.in_dec ? ST_CONV : ST_COMMIT;
                end
            end
            ST_CONV:   if (w_bcd_done) w_state_next = ST_COMMIT;
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Ready re-arms one cycle after returning to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= (r_state == ST_IDLE) && !w_accept;
            r_busy  <= !((r_state == ST_IDLE) && !w_accept);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value       <= '0;
            r_dec         <= 1'b0;
            r_blank_lz    <= 1'b0;
            r_disp_digits <= '0;
            r_disp_blank  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_value    <= in_bus.in_value;
                r_dec      <= in_bus.in_dec;
                r_blank_lz <= in_bus.in_blank_lz;
            end
            if (w_commit) begin
                r_disp_digits <= r_dec ? w_bcd : r_value;
                r_disp_blank  <= r_blank_lz;
            end
        end
    end

    // Segment/common pattern for the digit slot about to be entered
    always_comb begin
        w_pre_tc   = (r_pre == PRE_LAST);
        w_idx_next = r_idx + 2'd1;
        for (int k = 0; k < NUM_DIGITS; k++)
            w_zero[k] = (r_disp_digits[DIGIT_W*k +: DIGIT_W] == 4'd0);
        w_lead[3] = w_zero[3];
        w_lead[2] = w_zero[2] && w_lead[3];
        w_lead[1] = w_zero[1] && w_lead[2];
        w_lead[0] = w_zero[0] && w_lead[1];
        w_seg = hex_font(r_disp_digits[{w_idx_next, 2'b00} +: DIGIT_W]);
        if (r_disp_blank && (w_idx_next != 2'd0) && w_lead[w_idx_next])
            w_seg = FONT_BLANK;
        w_com = NUM_DIGITS'(1) << w_idx_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_idx <= '0;
            r_com <= NUM_DIGITS'(1) ^ COM_XOR;
            r_seg <= hex_font(4'd0);
        end else if (w_pre_tc) begin
            r_pre <= '0;
            r_idx <= w_idx_next;
            r_com <= w_com ^ COM_XOR;
            r_seg <= w_seg;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign in_bus.in_ready = r_ready;
    assign busy            = r_busy;
    assign com             = r_com;
    assign seg_7           = r_seg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller with a short scan period.
module tb_fnd_scan_controller;
    localparam int unsigned SCAN_DIV = 4;

    localparam logic [7:0] S0 = 8'b0000_0011;
    localparam logic [7:0] S1 = 8'b1001_1111;
    localparam logic [7:0] S2 = 8'b0010_0101;
    localparam logic [7:0] S3 = 8'b0000_1101;
    localparam logic [7:0] S4 = 8'b1001_1001;
    localparam logic [7:0] S5 = 8'b0100_1001;
    localparam logic [7:0] S7 = 8'b0001_1111;
    localparam logic [7:0] S9 = 8'b0000_1001;
    localparam logic [7:0] SA = 8'b0001_0001;
    localparam logic [7:0] SB = 8'b1100_0001;
    localparam logic [7:0] SE = 8'b0110_0001;
    localparam logic [7:0] SF = 8'b0111_0001;
    localparam logic [7:0] SX = 8'b1111_1111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy;
    logic [3:0] com;
    logic [7:0] seg_7;
    int         n_cmp = 0;
    int         n_err = 0;

    fnd_scan_controller_if bus ();

    fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .COM_ACTIVE_LOW(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bus  (bus),
        .busy    (busy),
        .com     (com),
        .seg_7   (seg_7)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input logic dec, input logic blank);
        bus.in_valid    = 1'b1;
        bus.in_value    = v;
        bus.in_dec      = dec;
        bus.in_blank_lz = blank;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    // Align to the start of a fresh digit-0 slot and record all four slots
    task automatic capture_scan(output logic [31:0] segs, output logic [15:0] coms, output bit to);
        logic [3:0] prev;
        int n;
        n = 0;
        prev = com;
        segs = '0;
        coms = '0;
        while (com === prev && n < 40) begin tick(); n++; end
        while (com !== 4'b0001 && n < 40) begin tick(); n++; end
        to = (n >= 40);
        for (int k = 0; k < 4; k++) begin
            segs[8*k +: 8] = seg_7;
            coms[4*k +: 4] = com;
            repeat (SCAN_DIV) tick();
        end
    endtask

    task automatic compare_scan(input string name, input logic [31:0] exp);
        logic [31:0] segs;
        logic [15:0] coms;
        bit to;
        capture_scan(segs, coms, to);
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL %s scan_align: timed out waiting for digit-0 slot, com=%b", name, com);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (segs[8*k +: 8] !== exp[8*k +: 8] || coms[4*k +: 4] !== 4'(1 << k)) begin
                n_err++;
                $display("FAIL %s digit%0d: com=%b seg_7=%b, required com=%b seg_7=%b",
                         name, k, coms[4*k +: 4], segs[8*k +: 8], 4'(1 << k), exp[8*k +: 8]);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_value = '0; bus.in_dec = 1'b0; bus.in_blank_lz = 1'b0;
        repeat (3) tick();
        n_cmp++; if (com !== 4'b0001) begin n_err++; $display("FAIL reset_com: got %b want 0001", com); end
        n_cmp++; if (seg_7 !== S0) begin n_err++; $display("FAIL reset_seg: got %b want %b", seg_7, S0); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        n = 0;
        while (com === 4'b0001 && n < 20) begin tick(); n++; end
        n_cmp++; if (n != 4 || com !== 4'b0010) begin n_err++; $display("FAIL scan_step1: %0d clks com=%b, want 4 clks com=0010", n, com); end
        n = 0;
        while (com === 4'b0010 && n < 20) begin tick(); n++; end
        n_cmp++; if (n != 4 || com !== 4'b0100) begin n_err++; $display("FAIL scan_step2: %0d clks com=%b, want 4 clks com=0100", n, com); end
    endtask

    task automatic load(input string name, input logic [15:0] v, input logic dec, input logic blank, input int lat);
        int n;
        n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s pre_ready: ready=%b busy=%b want 1/0", name, bus.in_ready, busy); end
        send(v, dec, blank);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy); end
        wait_ready(n);
        n_cmp++; if (n != lat) begin n_err++; $display("FAIL %s ready_latency: got %0d want %0d", name, n, lat); end
    endtask

    task automatic test_dec_1234();
        load("dec1234", 16'd1234, 1'b1, 1'b0, 14);
        compare_scan("dec1234", {S1, S2, S3, S4});
    endtask

    task automatic test_hex_beef();
        load("hexBEEF", 16'hBEEF, 1'b0, 1'b0, 2);
        compare_scan("hexBEEF", {SB, SE, SE, SF});
    endtask

    task automatic test_blank_lz();
        load("dec7_blank", 16'd7, 1'b1, 1'b1, 14);
        compare_scan("dec7_blank", {SX, SX, SX, S7});
        load("dec0_blank", 16'd0, 1'b1, 1'b1, 14);
        compare_scan("dec0_blank", {SX, SX, SX, S0});
        load("hex00A0_blank", 16'h00A0, 1'b0, 1'b1, 2);
        compare_scan("hex00A0_blank", {SX, SX, SA, S0});
    endtask

    task automatic test_back_to_back();
        int n;
        send(16'hF_FFF, 1'b1, 1'b0);
        bus.in_valid = 1'b1; bus.in_value = 16'h0001; bus.in_dec = 1'b0;
        wait_ready(n);
        n_cmp++; if (n != 14) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 14", n); end
        n_cmp++; if (dut.r_disp_digits !== 16'h4095) begin n_err++; $display("FAIL b2b_first_value: got %h want 4095", dut.r_disp_digits); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: ready=%b want 0", bus.in_ready); end
        wait_ready(n);
        n_cmp++; if (n != 2) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 2", n); end
        compare_scan("b2b_hex0001", {S0, S0, S0, S1});
    endtask

    task automatic test_reset_mid_conv();
        send(16'd999, 1'b1, 1'b0);
        repeat (5) tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL midconv_busy: ready=%b want 0", bus.in_ready); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midconv_reset_ready: ready=%b busy=%b want 1/0", bus.in_ready, busy); end
        n_cmp++; if (com !== 4'b0001 || seg_7 !== S0) begin n_err++; $display("FAIL midconv_reset_pins: com=%b seg=%b want 0001/%b", com, seg_7, S0); end
        tick();
        reset_n = 1'b1;
        compare_scan("midconv_aborted", {S0, S0, S0, S0});
        load("dec999_retry", 16'd999, 1'b1, 1'b0, 14);
        compare_scan("dec999_retry", {S0, S9, S9, S9});
    endtask

    initial begin
        test_reset();
        test_dec_1234();
        test_hex_beef();
        test_blank_lz();
        test_back_to_back();
        test_reset_mid_conv();
        load("dec5_final", 16'd5, 1'b1, 1'b0, 14);
        compare_scan("dec5_final", {S0, S0, S0, S5});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Sequencer for the 4-digit 7-segment FND on the Cora board.
- Accepts a value over a valid/ready handshake and, in decimal mode, converts binary to BCD sequentially, one bit per cycle.
- Commits the resulting four digits atomically into a display register.
- Time-multiplexes the digits onto the shared seg_7/com pins.
- Replaces free-running clock-divider display demos as the single owner of the FND pins.

Parameters:
SCAN_DIV, 125000, clk cycles per digit slot (1 ms at 125 MHz); legal range ≥2; counter width = $clog2(SCAN_DIV)
COM_ACTIVE_LOW, 0, 0: com one-hot active-high; 1: com bits inverted

Ports:
clk  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request to load in_value
in_ready  output  1  block can accept; high only in IDLE
in_value  input  16  hex mode: 4 hex digits; decimal mode: only [11:0] used (0..4095)
in_dec  input  1  1 = decimal (BCD-convert), 0 = hex; sampled at accept
in_blank_lz  input  1  1 = blank leading zero digits; sampled at accept
busy  output  1  ~in_ready
com  output  4  digit select, one-hot; bit0 = rightmost digit
seg_7  output  8  segment font, active-low, {a,b,c,d,e,f,g,dp}, dp always 1

Behaviour:
- Decided: one clock (clk); reset is asynchronous and active-low (reset_n).
- Accept occurs on a clk edge where in_valid && in_ready. On accept, latch in_value, in_dec and in_blank_lz.
- FSM states and transitions:
  - IDLE: in_ready = 1. On accept, go to CONV if in_dec, else go to COMMIT.
  - CONV: 12 cycles. Iteration counter runs 0..11. Each cycle:
    - Add 3 to every BCD nibble that is ≥5.
    - Then shift {bcd[15:0]} left by 1, inserting bin[11-i] (MSB first).
    - After i = 11, go to COMMIT.
  - COMMIT: 1 cycle.
    - Write disp_digits[15:0] = BCD result (decimal) or latched in_value (hex).
    - Write disp_blank.
    - Go to IDLE.
- Latency from the accept edge:
  - Hex: disp_digits updated at edge +1; in_ready returns at +2.
  - Decimal: disp_digits updated at edge +13; in_ready returns at +14.
  - New content reaches the pins at the next digit-slot change after commit.
- in_valid while not in IDLE is ignored; the requester must hold it. There is no queueing.
- The display never tears: during CONV the old disp_digits keep scanning.
- Scan logic:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, digit index advances 0→1→2→3→0.
  - com and seg_7 are registered and update on the same edge as the index.
- seg_7 content:
  - seg_7 = font(disp_digits[4*idx+3 : 4*idx]) using the team's hex font, e.g. 0 = 8'b0000_0011, F = 8'b0111_0001.
  - Leading-zero blanking applies when disp_blank = 1. Digit k (k = 1..3) shows 8'b1111_1111 if it and all higher digits are zero.
  - Digit 0 is never blanked.
- Reset values:
  - FSM = IDLE; prescaler = 0; idx = 0; iteration counter = 0.
  - disp_digits = 0; disp_blank = 0.
  - com = 4'b0001 (inverted if COM_ACTIVE_LOW); seg_7 = 8'b0000_0011.
  - in_ready = 1; busy = 0.
- Reset mid-CONV or mid-COMMIT aborts the conversion; no partial commit survives.
- in_value[15:12] is ignored in decimal mode.

Decomposition:
- Package fnd_pkg:
  - FSM state localparams (IDLE/CONV/COMMIT).
  - FONT_BLANK = 8'hFF.
  - Digit count 4; conversion bit count 12.
  - Hex font function (16-entry table).
- One natural sub-module: fnd_bcd_seq, the sequential double-dabble engine.
  - Interface: start, bin[11:0], done, bcd[15:0].
  - The top module keeps the handshake, commit and scan logic.

Test Plan:
1. Assert reset_n=0 then release, with SCAN_DIV=4 → com=0001, seg_7=0000_0011, in_ready=1, busy=0; idx advances every 4 clk.
2. Decimal 12'd1234 accepted → in_ready low for 14 cycles. Scan then shows:
   - com 0001 → seg_7 1001_1001
   - com 0010 → 0000_1101
   - com 0100 → 0010_0101
   - com 1000 → 1001_1111
3. Hex 16'hBEEF, blank off, accepted → commit at +1. Scan shows:
   - digit0 0111_0001
   - digit1 0110_0001
   - digit2 0110_0001
   - digit3 1100_0001
4. Decimal 7 with blank_lz=1 → digits 3..1 = 1111_1111, digit0 = 0001_1111. Decimal 0 with blank_lz=1 → digit0 = 0000_0011, others blank.
5. Decimal 4095, then hold in_valid with hex 16'h0001 during CONV → second value is not accepted until IDLE. Display shows 4,0,9,5 and then 0,0,0,1.
6. reset_n pulsed low at CONV cycle 5 of decimal 999 → immediate IDLE; disp shows 0; com = 0001; a later accept completes normally.
